// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution stage: condition codes,
// NZCV bit positions and FlagW field positions.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/condcheck.sv
// Combinational ARM condition evaluation: condition field x NZCV -> execute/skip.
// Kept free of state so a pipelined core can reuse it directly.
module condcheck
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       condEx_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // The 1111 encoding is treated as "never" rather than unconditional.
    always_comb begin
        condEx_o = 1'b0;
        case (cond_i)
            COND_EQ: condEx_o = z;
            COND_NE: condEx_o = ~z;
            COND_CS: condEx_o = c;
            COND_CC: condEx_o = ~c;
            COND_MI: condEx_o = n;
            COND_PL: condEx_o = ~n;
            COND_VS: condEx_o = v;
            COND_VC: condEx_o = ~v;
            COND_HI: condEx_o = c & ~z;
            COND_LS: condEx_o = ~c | z;
            COND_GE: condEx_o = (n == v);
            COND_LT: condEx_o = (n != v);
            COND_GT: condEx_o = ~z & (n == v);
            COND_LE: condEx_o = z | (n != v);
            COND_AL: condEx_o = 1'b1;
            COND_NV: condEx_o = 1'b0;
            default: condEx_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, latches the condition result in the
// decode cycle and gates decoder write requests. CONDUNIT_STATS_EN adds exec/squash counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             FPUW,
    input  logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             FPUWrite,
    output logic [3:0]       Flags,
    output logic             CondExReg
`ifdef CONDUNIT_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
`endif
);

    generate
        if (CNT_W < 1) begin : gBadCntW
            $error("cond_unit: CNT_W must be at least 1");
        end
    endgenerate

    logic [3:0] flags_q, flags_d;
    logic       condExReg_q;
    logic       irw_q;
    logic       condEx;

    condcheck u_condcheck (
        .cond_i   (Cond),
        .flags_i  (flags_q),
        .condEx_o (condEx)
    );

    // Flag writes are gated by the latched result of the instruction in flight.
    always_comb begin
        flags_d = flags_q;
        if (FlagW[FLAGW_NZ] && condExReg_q) begin
            flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
        end
        if (FlagW[FLAGW_CV] && condExReg_q) begin
            flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            condExReg_q <= 1'b0;
            irw_q       <= 1'b0;
        end else begin
            flags_q <= flags_d;
            irw_q   <= IRWrite;
            if (irw_q) begin
                condExReg_q <= condEx;
            end
        end
    end

    assign PCWrite   = NextPC | (PCS & condExReg_q);
    assign RegWrite  = RegW & condExReg_q;
    assign MemWrite  = MemW & condExReg_q;
    assign FPUWrite  = FPUW & condExReg_q;
    assign Flags     = flags_q;
    assign CondExReg = condExReg_q;

`ifdef CONDUNIT_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] execCount_q;
    logic [CNT_W-1:0] squashCount_q;

    // One count per decode cycle; both counters stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            execCount_q   <= '0;
            squashCount_q <= '0;
        end else if (irw_q) begin
            if (condEx) begin
                if (execCount_q != '1) begin
                    execCount_q <= execCount_q + CNT_ONE;
                end
            end else if (squashCount_q != '1) begin
                squashCount_q <= squashCount_q + CNT_ONE;
            end
        end
    end

    assign ExecCount   = execCount_q;
    assign SquashCount = squashCount_q;
`endif

endmodule
